interrupt_sequencer: RTL and testbench

Multi-cycle controller that turns a raised `interrupt_signal` into a fixed sequence of pipeline actions, then restarts execution at a vector loaded from data memory. The sequence is:
- stall and flush fetch,
- drain in-flight instructions,
- push the return PC, plus flags when flag saving is compiled in,
- read a 32-bit handler vector from data memory,
- load it into the PC.

It sits beside the hazard controller. It injects push and read operations into the memory stage through a request/grant handshake, and drives the fetch stage's PC-write and stall controls.

---
 rtl/interrupt_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
//
// Turns a rising edge on interrupt_signal into a fixed pipeline sequence:
// stall and flush fetch, drain in-flight instructions, push the return PC
// (and flags when INT_FLAG_SAVE_EN is defined), read a 32-bit handler vector
// from data memory, then load it into the PC.
//
// Build option:
//   INT_FLAG_SAVE_EN  when defined, the flags word is pushed after the PC
//                     (three pushes); otherwise only the PC is pushed.
//
// Parameters:
//   DRAIN_CYCLES  cycles waited after the flush before the first push
//   VECTOR_ADDR   address of the vector high word (low word at +1, wraps)
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   interrupt_signal     interrupt request (rising edge sampled)
//   int_enable           global interrupt enable (checked in IDLE only)
//   branch_pending       unresolved branch/jump, blocks entry
//   pc_next, flags       return PC and flag register captured at entry
//   mem_gnt              memory stage accepted the current request
//   mem_rvalid/rdata     read data return
//   mem_req/push/read    injected memory operation and its kind
//   mem_addr, mem_wdata  read address / push data
//   stall_fetch          hold fetch while the sequence runs
//   flush_fetch          one-cycle pulse at sequence entry
//   pc_write, pc_value   load handler PC into fetch
//   int_active           sequence in progress
module interrupt_sequencer #(
    parameter int          DRAIN_CYCLES = 3,
    parameter logic [15:0] VECTOR_ADDR  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        interrupt_signal,
    input  logic        int_enable,
    input  logic        branch_pending,
    input  logic [31:0] pc_next,
    input  logic [2:0]  flags,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [15:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_push,
    output logic        mem_read,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        stall_fetch,
    output logic        flush_fetch,
    output logic        pc_write,
    output logic [31:0] pc_value,
    output logic        int_active
);

    localparam int CNT_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD =
        CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [3:0] {
        IDLE,
        DRAIN,
        PUSH_HI,
        PUSH_LO,
`ifdef INT_FLAG_SAVE_EN
        PUSH_FLG,
`endif
        VEC_HI_REQ,
        VEC_HI_WAIT,
        VEC_LO_REQ,
        VEC_LO_WAIT,
        LOAD
    } state_t;

    state_t           state, state_nxt;
    logic             int_q1, int_q2;
    logic             pending;
    logic [CNT_W-1:0] drain_cnt;
    logic [31:0]      pc_cap;
    logic             int_edge;
    logic             entry;

`ifdef INT_FLAG_SAVE_EN
    logic [2:0]       flags_cap;
`else
    logic             unused_flags;
    assign unused_flags = ^flags;
`endif

    // The edge is taken between the registered copy and its delayed copy,
    // so pending rises two cycles after the request.
    assign int_edge = int_q1 & ~int_q2;
    assign entry    = (state == IDLE) && pending && int_enable && !branch_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            int_q1    <= 1'b0;
            int_q2    <= 1'b0;
            pending   <= 1'b0;
            drain_cnt <= '0;
            pc_cap    <= '0;
            pc_value  <= '0;
`ifdef INT_FLAG_SAVE_EN
            flags_cap <= '0;
`endif
        end else begin
            state  <= state_nxt;
            int_q1 <= interrupt_signal;
            int_q2 <= int_q1;

            // An edge coinciding with entry is kept so a second sequence follows.
            if (entry)
                pending <= int_edge;
            else if (int_edge)
                pending <= 1'b1;

            if (entry) begin
                pc_cap    <= pc_next;
                drain_cnt <= DRAIN_LOAD;
`ifdef INT_FLAG_SAVE_EN
                flags_cap <= flags;
`endif
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end

            if (state == VEC_HI_WAIT && mem_rvalid)
                pc_value[31:16] <= mem_rdata;
            if (state == VEC_LO_WAIT && mem_rvalid)
                pc_value[15:0] <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt   = state;
        mem_req     = 1'b0;
        mem_push    = 1'b0;
        mem_read    = 1'b0;
        mem_addr    = 16'h0000;
        mem_wdata   = 16'h0000;
        flush_fetch = 1'b0;
        pc_write    = 1'b0;
        stall_fetch = (state != IDLE);
        int_active  = (state != IDLE);

        case (state)
            IDLE: begin
                if (entry) begin
                    flush_fetch = 1'b1;
                    state_nxt   = (DRAIN_CYCLES == 0) ? PUSH_HI : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0)
                    state_nxt = PUSH_HI;
            end
            PUSH_HI: begin
                mem_req   = 1'b1;
                mem_push  = 1'b1;
                mem_wdata = pc_cap[31:16];
                if (mem_gnt)
                    state_nxt = PUSH_LO;
            end
            PUSH_LO: begin
                mem_req   = 1'b1;
                mem_push  = 1'b1;
                mem_wdata = pc_cap[15:0];
                if (mem_gnt)
`ifdef INT_FLAG_SAVE_EN
                    state_nxt = PUSH_FLG;
`else
                    state_nxt = VEC_HI_REQ;
`endif
            end
`ifdef INT_FLAG_SAVE_EN
            PUSH_FLG: begin
                mem_req   = 1'b1;
                mem_push  = 1'b1;
                mem_wdata = {13'b0, flags_cap};
                if (mem_gnt)
                    state_nxt = VEC_HI_REQ;
            end
`endif
            VEC_HI_REQ: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                mem_addr = VECTOR_ADDR;
                if (mem_gnt)
                    state_nxt = VEC_HI_WAIT;
            end
            VEC_HI_WAIT: begin
                if (mem_rvalid)
                    state_nxt = VEC_LO_REQ;
            end
            VEC_LO_REQ: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                mem_addr = VECTOR_ADDR + 16'd1;
                if (mem_gnt)
                    state_nxt = VEC_LO_WAIT;
            end
            VEC_LO_WAIT: begin
                if (mem_rvalid)
                    state_nxt = LOAD;
            end
            LOAD: begin
                pc_write  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

    localparam int DRAIN = 3;
`ifdef INT_FLAG_SAVE_EN
    localparam int NPUSH = 3;
`else
    localparam int NPUSH = 2;
`endif
    // Cycles from the entry (flush) cycle to the LOAD cycle with immediate grants.
    localparam int LAT = 1 + DRAIN + NPUSH + 4;

    logic        clk;
    logic        rst;
    logic        interrupt_signal;
    logic        int_enable;
    logic        branch_pending;
    logic [31:0] pc_next;
    logic [2:0]  flags;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_req;
    logic        mem_push;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        stall_fetch;
    logic        flush_fetch;
    logic        pc_write;
    logic [31:0] pc_value;
    logic        int_active;

    logic        gnt_en;
    logic [15:0] vec_hi, vec_lo;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  kind;   // 0 push, 1 read, 2 pc load
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];

    interrupt_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .interrupt_signal (interrupt_signal),
        .int_enable       (int_enable),
        .branch_pending   (branch_pending),
        .pc_next          (pc_next),
        .flags            (flags),
        .mem_gnt          (mem_gnt),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .mem_req          (mem_req),
        .mem_push         (mem_push),
        .mem_read         (mem_read),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .stall_fetch      (stall_fetch),
        .flush_fetch      (flush_fetch),
        .pc_write         (pc_write),
        .pc_value         (pc_value),
        .int_active       (int_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory-stage responder: grants when enabled, returns read data one cycle later.
    assign mem_gnt = mem_req & gnt_en;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= 16'h0000;
        end else begin
            mem_rvalid <= mem_req & mem_read & mem_gnt;
            mem_rdata  <= (mem_addr == 16'h0000) ? vec_hi :
                          (mem_addr == 16'h0001) ? vec_lo : 16'hDEAD;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input logic [1:0] kind, input logic [31:0] val);
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_extra: got kind %0d value %h, expected nothing", kind, val);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", {30'b0, kind}, {30'b0, e.kind});
            chk("sb_value", val, e.val);
        end
    endtask

    // Monitor: every granted request and every PC load is checked against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && mem_gnt) begin
                if (mem_push)
                    sb_check(2'd0, {16'h0, mem_wdata});
                else
                    sb_check(2'd1, {16'h0, mem_addr});
            end
            if (pc_write)
                sb_check(2'd2, pc_value);
        end
    end

    task automatic expect_seq(input logic [31:0] pc, input logic [2:0] flg,
                              input logic [15:0] hi, input logic [15:0] lo);
        sbq.push_back('{2'd0, {16'h0, pc[31:16]}});
        sbq.push_back('{2'd0, {16'h0, pc[15:0]}});
`ifdef INT_FLAG_SAVE_EN
        sbq.push_back('{2'd0, {29'h0, flg}});
`else
        if (flg == 3'b111) begin end
`endif
        sbq.push_back('{2'd1, 32'h0000_0000});
        sbq.push_back('{2'd1, 32'h0000_0001});
        sbq.push_back('{2'd2, {hi, lo}});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_flush(input string nm);
        int n = 0;
        while (!flush_fetch && n < 20) begin
            step();
            n++;
        end
        chk(nm, {31'b0, flush_fetch}, 32'd1);
    endtask

    task automatic run_to_load(output int cyc, output int nfl);
        cyc = 0;
        nfl = 0;
        while (!pc_write && cyc < 200) begin
            if (flush_fetch) nfl++;
            step();
            cyc++;
        end
        chk("load_reached", {31'b0, pc_write}, 32'd1);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, "_req"},   {31'b0, mem_req},     32'd0);
        chk({nm, "_push"},  {31'b0, mem_push},    32'd0);
        chk({nm, "_read"},  {31'b0, mem_read},    32'd0);
        chk({nm, "_addr"},  {16'b0, mem_addr},    32'd0);
        chk({nm, "_wdata"}, {16'b0, mem_wdata},   32'd0);
        chk({nm, "_stall"}, {31'b0, stall_fetch}, 32'd0);
        chk({nm, "_flush"}, {31'b0, flush_fetch}, 32'd0);
        chk({nm, "_pcw"},   {31'b0, pc_write},    32'd0);
        chk({nm, "_pcval"}, pc_value,             32'd0);
        chk({nm, "_act"},   {31'b0, int_active},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, nfl, n;

        rst = 1'b1;
        interrupt_signal = 1'b0;
        int_enable = 1'b1;
        branch_pending = 1'b0;
        pc_next = 32'h0;
        flags = 3'b0;
        gnt_en = 1'b1;
        vec_hi = 16'h0000;
        vec_lo = 16'h0040;

        // Reset state
        step();
        chk_idle_outputs("rst");
        step();
        rst = 1'b0;
        step();
        chk_idle_outputs("post_rst");

        // Basic sequence with edge latency and cycle count
        pc_next = 32'h0001_0025;
        flags = 3'b101;
        expect_seq(32'h0001_0025, 3'b101, 16'h0000, 16'h0040);
        interrupt_signal = 1'b1;
        step();
        chk("edge_lat1_flush", {31'b0, flush_fetch}, 32'd0);
        step();
        chk("edge_lat2_flush", {31'b0, flush_fetch}, 32'd1);
        chk("entry_act", {31'b0, int_active}, 32'd0);
        run_to_load(cyc, nfl);
        chk("basic_latency", cyc, LAT);
        chk("basic_flush_count", nfl, 32'd1);
        chk("basic_stall_in_load", {31'b0, stall_fetch}, 32'd1);
        step();
        chk("basic_stall_after", {31'b0, stall_fetch}, 32'd0);
        chk("basic_act_after", {31'b0, int_active}, 32'd0);
        chk("basic_pcval", pc_value, 32'h0000_0040);
        interrupt_signal = 1'b0;
        repeat (3) step();

        // branch_pending blocks entry; entry follows its release
        vec_hi = 16'hABCD;
        vec_lo = 16'h1234;
        pc_next = 32'hDEAD_BEEF;
        flags = 3'b010;
        branch_pending = 1'b1;
        expect_seq(32'hDEAD_BEEF, 3'b010, 16'hABCD, 16'h1234);
        interrupt_signal = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("br_blocked_flush", {31'b0, flush_fetch}, 32'd0);
            chk("br_blocked_act", {31'b0, int_active}, 32'd0);
        end
        branch_pending = 1'b0;
        #1;
        chk("br_release_flush", {31'b0, flush_fetch}, 32'd1);
        run_to_load(cyc, nfl);
        chk("br_latency", cyc, LAT);
        step();
        chk("br_pcval", pc_value, 32'hABCD_1234);
        interrupt_signal = 1'b0;
        repeat (3) step();

        // Grant withheld for 5 cycles in PUSH_HI
        vec_hi = 16'h0000;
        vec_lo = 16'h0040;
        pc_next = 32'h0001_0025;
        flags = 3'b101;
        gnt_en = 1'b0;
        expect_seq(32'h0001_0025, 3'b101, 16'h0000, 16'h0040);
        interrupt_signal = 1'b1;
        wait_flush("hold_entry");
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", {31'b0, mem_req}, 32'd1);
            chk("hold_push", {31'b0, mem_push}, 32'd1);
            chk("hold_wdata", {16'b0, mem_wdata}, 32'h0000_0001);
            step();
        end
        chk("hold_still_hi", {16'b0, mem_wdata}, 32'h0000_0001);
        gnt_en = 1'b1;
        run_to_load(cyc, nfl);
        step();
        interrupt_signal = 1'b0;
        repeat (3) step();

        // Second edge during VEC_LO_WAIT: one IDLE cycle then a new sequence
        pc_next = 32'h0002_0003;
        flags = 3'b011;
        expect_seq(32'h0002_0003, 3'b011, 16'h0000, 16'h0040);
        expect_seq(32'h0004_0005, 3'b110, 16'h0000, 16'h0040);
        interrupt_signal = 1'b1;
        wait_flush("b2b_entry1");
        step();
        interrupt_signal = 1'b0;
        pc_next = 32'h0004_0005;
        flags = 3'b110;
        n = 0;
        while (!(mem_req && mem_read && mem_addr == 16'h0001) && n < 40) begin
            step();
            n++;
        end
        chk("b2b_reach_vlr", {31'b0, mem_read}, 32'd1);
        interrupt_signal = 1'b1;
        run_to_load(cyc, nfl);
        step();
        chk("b2b_idle_act", {31'b0, int_active}, 32'd0);
        chk("b2b_idle_flush", {31'b0, flush_fetch}, 32'd1);
        step();
        chk("b2b_restart_act", {31'b0, int_active}, 32'd1);
        chk("b2b_restart_flush", {31'b0, flush_fetch}, 32'd0);
        run_to_load(cyc, nfl);
        step();
        interrupt_signal = 1'b0;
        repeat (3) step();

        // Reset in PUSH_LO, then a clean sequence
        pc_next = 32'h0001_0025;
        flags = 3'b101;
        expect_seq(32'h0001_0025, 3'b101, 16'h0000, 16'h0040);
        interrupt_signal = 1'b1;
        wait_flush("rst_entry");
        n = 0;
        while (!(mem_push && mem_wdata == 16'h0025) && n < 20) begin
            step();
            n++;
        end
        chk("rst_reach_pushlo", {16'b0, mem_wdata}, 32'h0000_0025);
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        sbq.delete();
        interrupt_signal = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk("postrst_act", {31'b0, int_active}, 32'd0);
        chk("postrst_flush", {31'b0, flush_fetch}, 32'd0);

        vec_hi = 16'h1111;
        vec_lo = 16'h2222;
        pc_next = 32'h0007_0008;
        flags = 3'b001;
        expect_seq(32'h0007_0008, 3'b001, 16'h1111, 16'h2222);
        interrupt_signal = 1'b1;
        wait_flush("clean_entry");
        run_to_load(cyc, nfl);
        chk("clean_latency", cyc, LAT);
        chk("clean_flush_count", nfl, 32'd1);
        step();
        chk("clean_pcval", pc_value, 32'h1111_2222);
        interrupt_signal = 1'b0;
        repeat (3) step();

        chk("sb_drained", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
